// File: rtl/vsim_ser_pkg.sv
// Shared types and helpers for the vsim_msg_serializer codebase slice:
// FSM state encoding, header packing and the length-field width helper.
package vsim_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
  } ser_state_e;

  // Widest beat the header helper supports; callers cast the result down.
  localparam int HDR_MAX_W  = 128;
  localparam int HDR_HALF_W = HDR_MAX_W / 2;

  // Width needed to hold a payload word count of 0..max_words.
  function automatic int calc_len_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  // Header beat: id in the upper half, total beat count (truncated) in the lower half.
  function automatic logic [HDR_MAX_W-1:0] pack_header(
    input logic [HDR_HALF_W-1:0] id,
    input logic [HDR_HALF_W-1:0] count,
    input int                    half_w
  );
    logic [HDR_MAX_W-1:0] mask;
    mask = (HDR_MAX_W'(1) << half_w) - HDR_MAX_W'(1);
    return (HDR_MAX_W'(id) << half_w) | (HDR_MAX_W'(count) & mask);
  endfunction

endpackage

// File: rtl/vsim_ser_wordbuf.sv
// Payload capture buffer for vsim_msg_serializer: MAX_WORDS x width
// registers loaded in one cycle, read through a combinational index port.
module vsim_ser_wordbuf
  import vsim_ser_pkg::*;
#(
  parameter int width     = 32,
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = calc_len_w(MAX_WORDS)
) (
  input  logic                       CLK,
  input  logic                       i_load,
  input  logic [MAX_WORDS*width-1:0] i_data,
  input  logic [LEN_W-1:0]           i_idx,
  output logic [width-1:0]           o_word
);

  logic [width-1:0] r_mem [MAX_WORDS];

  // Capture every payload word when a message is accepted.
  // NOTE: the payload store has no reset; words are only read after a load, and reset returns the FSM to IDLE so stale contents are never emitted.
  always_ff @(posedge CLK) begin
    if (i_load) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        r_mem[k] <= i_data[k*width +: width];
      end
    end
  end

  // Index read port; out-of-range indices read as zero instead of addressing past the array.
  always_comb begin
    // NOTE: default assignment first so no path leaves o_word unassigned and infers a latch.
    o_word = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (i_idx == LEN_W'(k)) o_word = r_mem[k];
    end
  end

endmodule

// File: rtl/vsim_msg_serializer.sv
// Message serializer: accepts one message (id + up to MAX_WORDS words) per
// EN_msg/RDY_msg handshake and emits a header beat followed by payload beats
// on the EN_beat/RDY_beat port, with `last` on the final beat.
// Optional build macro VSIM_SER_STATS_EN adds stat_msgs / stat_beats counters.
module vsim_msg_serializer
  import vsim_ser_pkg::*;
#(
  parameter int width     = 32,
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = calc_len_w(MAX_WORDS)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       EN_msg,
  output logic                       RDY_msg,
  input  logic [width/2-1:0]         msg_id,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic [MAX_WORDS*width-1:0] msg_data,
  output logic                       RDY_beat,
  input  logic                       EN_beat,
  output logic [width-1:0]           beat,
  output logic                       last,
  output logic                       err_len
`ifdef VSIM_SER_STATS_EN
  ,
  output logic [31:0]                stat_msgs,
  output logic [31:0]                stat_beats
`endif
);

  localparam int HALF_W = width / 2;
  localparam int CNT_W  = LEN_W + 1;

  ser_state_e        r_state;
  logic              r_rdy_beat;
  logic [width-1:0]  r_beat;
  logic              r_last;
  logic              r_err_len;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;

  logic              w_accept;
  logic              w_consume;
  logic              w_len_over;
  logic [LEN_W-1:0]  w_len_clamp;
  logic [CNT_W-1:0]  w_hdr_cnt;
  logic [width-1:0]  w_hdr_beat;
  logic [LEN_W-1:0]  w_rd_idx;
  logic [width-1:0]  w_rd_word;
  logic              w_next_last;

  assign RDY_msg   = (r_state == IDLE) && !nRST;
  assign w_accept  = EN_msg && RDY_msg;
  assign w_consume = EN_beat && r_rdy_beat;

  assign w_len_over  = msg_len > LEN_W'(MAX_WORDS);
  assign w_len_clamp = w_len_over ? LEN_W'(MAX_WORDS) : msg_len;
  assign w_hdr_cnt   = {1'b0, w_len_clamp} + CNT_W'(1);
  assign w_hdr_beat  = width'(pack_header(HDR_HALF_W'(msg_id), HDR_HALF_W'(w_hdr_cnt), HALF_W));

  // Word that becomes the beat after the current one is consumed.
  assign w_rd_idx    = (r_state == HDR) ? '0 : r_idx + LEN_W'(1);
  assign w_next_last = ({1'b0, w_rd_idx} + CNT_W'(1)) == {1'b0, r_len};

  vsim_ser_wordbuf #(
    .width     (width),
    .MAX_WORDS (MAX_WORDS),
    .LEN_W     (LEN_W)
  ) u_wordbuf (
    .CLK    (CLK),
    .i_load (w_accept),
    .i_data (msg_data),
    .i_idx  (w_rd_idx),
    .o_word (w_rd_word)
  );

  // Message FSM with registered beat-port outputs.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state    <= IDLE;
      r_rdy_beat <= 1'b0;
      r_beat     <= '0;
      r_last     <= 1'b0;
      r_err_len  <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= HDR;
            r_len      <= w_len_clamp;
            r_idx      <= '0;
            r_rdy_beat <= 1'b1;
            r_beat     <= w_hdr_beat;
            r_last     <= (w_len_clamp == '0);
            if (w_len_over) r_err_len <= 1'b1;
          end
        end
        HDR, BODY: begin
          if (w_consume) begin
            if (r_last) begin
              r_state    <= IDLE;
              r_rdy_beat <= 1'b0;
              r_beat     <= '0;
              r_last     <= 1'b0;
            end else begin
              r_state <= BODY;
              r_idx   <= w_rd_idx;
              r_beat  <= w_rd_word;
              r_last  <= w_next_last;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_rdy_beat <= 1'b0;
        end
      endcase
    end
  end

  assign RDY_beat = r_rdy_beat;
  assign beat     = r_beat;
  assign last     = r_last;
  assign err_len  = r_err_len;

`ifdef VSIM_SER_STATS_EN
  logic [31:0] r_stat_msgs;
  logic [31:0] r_stat_beats;

  // Free-running message and beat counters, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_stat_msgs  <= '0;
      r_stat_beats <= '0;
    end else begin
      if (w_accept)  r_stat_msgs  <= r_stat_msgs + 32'd1;
      if (w_consume) r_stat_beats <= r_stat_beats + 32'd1;
    end
  end

  assign stat_msgs  = r_stat_msgs;
  assign stat_beats = r_stat_beats;
`endif

endmodule

// File: tb/tb_vsim_msg_serializer.sv
// Self-checking bench for vsim_msg_serializer: expected beats are queued when
// a message is sent and compared as the DUT's beats are consumed.
// Stat counters are checked when built with VSIM_SER_STATS_EN.
module tb_vsim_msg_serializer;

  localparam int W  = 32;
  localparam int MW = 8;
  localparam int LW = $clog2(MW + 1);
  localparam int HW = W / 2;

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic              EN_msg = 1'b0;
  logic              RDY_msg;
  logic [HW-1:0]     msg_id = '0;
  logic [LW-1:0]     msg_len = '0;
  logic [MW*W-1:0]   msg_data = '0;
  logic              RDY_beat;
  logic              EN_beat = 1'b0;
  logic [W-1:0]      beat;
  logic              last;
  logic              err_len;
`ifdef VSIM_SER_STATS_EN
  logic [31:0]       stat_msgs;
  logic [31:0]       stat_beats;
`endif

  vsim_msg_serializer #(
    .width     (W),
    .MAX_WORDS (MW)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .EN_msg   (EN_msg),
    .RDY_msg  (RDY_msg),
    .msg_id   (msg_id),
    .msg_len  (msg_len),
    .msg_data (msg_data),
    .RDY_beat (RDY_beat),
    .EN_beat  (EN_beat),
    .beat     (beat),
    .last     (last),
    .err_len  (err_len)
`ifdef VSIM_SER_STATS_EN
    ,
    .stat_msgs  (stat_msgs),
    .stat_beats (stat_beats)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] beat;
    logic         last;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  int           n_consumed = 0;
  int           exp_msgs = 0;
  int           exp_beats = 0;
  logic [W-1:0] wds [MW];
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_beat = '0;
  logic         stall_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beat monitor: scoreboard compare on every consumed beat, stability check during stalls.
  always @(negedge CLK) begin
    if (nRST) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && RDY_beat) begin
        check("stall_beat", beat, stall_beat);
        check("stall_last", last, stall_last);
      end
      if (RDY_beat && EN_beat) begin
        n_consumed++;
        if (q.size() == 0) begin
          check("spurious_beat", q.size(), 1);
        end else begin
          mon_e = q.pop_front();
          check("beat", beat, mon_e.beat);
          check("last", last, mon_e.last);
        end
      end
      stall_prev = RDY_beat && !EN_beat;
      stall_beat = beat;
      stall_last = last;
    end
  end

  task automatic send_msg(input logic [HW-1:0] id, input int len);
    int   tmo;
    int   l_eff;
    exp_t e;
    tmo = 0;
    while (!RDY_msg && tmo < 100) begin
      @(posedge CLK); #1;
      tmo++;
    end
    check("rdy_msg_wait", tmo < 100, 1);
    msg_id  = id;
    msg_len = LW'(len);
    for (int k = 0; k < MW; k++) msg_data[k*W +: W] = wds[k];
    EN_msg  = 1'b1;
    l_eff = (len > MW) ? MW : len;
    e.beat = {id, HW'(l_eff + 1)};
    e.last = (l_eff == 0);
    q.push_back(e);
    for (int k = 0; k < l_eff; k++) begin
      e.beat = wds[k];
      e.last = (k == l_eff - 1);
      q.push_back(e);
    end
    exp_msgs++;
    exp_beats += l_eff + 1;
    @(posedge CLK); #1;
    EN_msg = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo = 0;
    while ((q.size() != 0 || !RDY_msg) && tmo < 200) begin
      @(posedge CLK); #1;
      tmo++;
    end
    check("drain_timeout", tmo < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] pat;
    int         base;

    for (int k = 0; k < MW; k++) wds[k] = '0;

    // Reset state.
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rdy_beat", RDY_beat, 0);
    check("rst_beat", beat, 0);
    check("rst_last", last, 0);
    check("rst_err_len", err_len, 0);
    check("rst_rdy_msg", RDY_msg, 0);
    nRST = 1'b0;
    #1;
    check("rdy_msg_after_rst", RDY_msg, 1);
    EN_beat = 1'b1;

    // Two-word message, cycle-exact beat sequence.
    wds[0] = 32'h0000_00A1;
    wds[1] = 32'h0000_00B2;
    send_msg(16'h0005, 2);
    check("t1_hdr_rdy", RDY_beat, 1);
    check("t1_hdr", beat, 32'h0005_0003);
    check("t1_hdr_last", last, 0);
    @(posedge CLK); #1;
    check("t1_w0", beat, 32'h0000_00A1);
    check("t1_w0_last", last, 0);
    @(posedge CLK); #1;
    check("t1_w1", beat, 32'h0000_00B2);
    check("t1_w1_last", last, 1);
    @(posedge CLK); #1;
    check("t1_rdy_msg_after", RDY_msg, 1);
    check("t1_rdy_beat_after", RDY_beat, 0);

    // Zero-length message: header only, flagged last.
    send_msg(16'h0007, 0);
    check("t2_hdr", beat, 32'h0007_0001);
    check("t2_last", last, 1);
    wait_idle();

    // Backpressure: EN_beat pattern 1,0,0,1,1 from the header cycle.
    EN_beat = 1'b0;
    send_msg(16'h0005, 2);
    base = n_consumed;
    pat  = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      EN_beat = pat[i];
      @(posedge CLK); #1;
    end
    EN_beat = 1'b0;
    check("t3_consumed", n_consumed - base, 3);
    check("t3_queue_empty", q.size(), 0);
    check("t3_rdy_msg", RDY_msg, 1);
    EN_beat = 1'b1;

    // Over-length message: clamped to MW words, err_len sticky.
    for (int k = 0; k < MW; k++) wds[k] = 32'hC000_0000 + k;
    send_msg(16'h0001, MW + 3);
    check("t4_hdr", beat, {16'h0001, HW'(MW + 1)});
    wait_idle();
    check("t4_err_len", err_len, 1);
    wds[0] = 32'hDEAD_0001;
    send_msg(16'h0002, 1);
    wait_idle();
    check("t4_err_len_held", err_len, 1);

    // Reset in the middle of a 4-word message.
    EN_beat = 1'b0;
    for (int k = 0; k < 4; k++) wds[k] = 32'h4000_0000 + k;
    send_msg(16'h0003, 4);
    check("t5_hdr_rdy", RDY_beat, 1);
    nRST = 1'b1;
    q.delete();
    @(posedge CLK); #1;
    check("t5_rst_rdy_beat", RDY_beat, 0);
    check("t5_rst_rdy_msg", RDY_msg, 0);
    check("t5_rst_beat", beat, 0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    exp_msgs  = 0;
    exp_beats = 0;
    check("t5_err_len_cleared", err_len, 0);
    EN_beat = 1'b1;
    wds[0] = 32'h5555_AAAA;
    send_msg(16'h0004, 1);
    check("t5_new_hdr", beat, 32'h0004_0002);
    wait_idle();
    check("t5_err_len_after", err_len, 0);

    // Back-to-back messages; EN_msg while busy is ignored.
    wds[0] = 32'h6000_0000;
    wds[1] = 32'h6000_0001;
    wds[2] = 32'h6000_0002;
    send_msg(16'h0008, 2);
    check("t6_busy_rdy_msg", RDY_msg, 0);
    msg_id  = 16'h0009;
    msg_len = LW'(1);
    EN_msg  = 1'b1;
    @(posedge CLK); #1;
    EN_msg  = 1'b0;
    send_msg(16'h000A, 3);
    wait_idle();
`ifdef VSIM_SER_STATS_EN
    check("t6_stat_msgs", stat_msgs, exp_msgs);
    check("t6_stat_beats", stat_beats, exp_beats);
`endif

    repeat (2) @(posedge CLK);
    #1;
    check("final_queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vsim_msg_serializer.md
# vsim_msg_serializer

Upstream stage of the simulation host-send path. Accepts one complete method-call message per handshake: a port/method id plus up to MAX_WORDS payload words. Emits it as a header beat followed by payload beats, with `last` on the final beat. Drives the beat-level EN/RDY port of the DPI sender stage.

## Interface
Parameters:
- width, 32, beat width in bits; must be even and ≥ 16.
- MAX_WORDS, 8, maximum payload words per message; ≥ 1.
- LEN_W, $clog2(MAX_WORDS+1), width of `msg_len`.

Ports:
- CLK  input  1  clock; all logic on posedge.
- nRST  input  1  reset; synchronous, active-high.
- EN_msg  input  1  message-accept strobe; acted on only when RDY_msg=1.
- RDY_msg  output  1  serializer idle and able to take a message.
- msg_id  input  width/2  port/method id.
- msg_len  input  LEN_W  payload word count, 0..MAX_WORDS.
- msg_data  input  MAX_WORDS*width  payload; word k at [k*width +: width].
- RDY_beat  output  1  beat valid toward the sender.
- EN_beat  input  1  sender consumes the beat; acted on only when RDY_beat=1.
- beat  output  width  current beat.
- last  output  1  current beat is the final beat of its message.
- err_len  output  1  sticky: a message with msg_len > MAX_WORDS was accepted.

## Operation
- FSM states: IDLE, HDR, BODY.
- IDLE: RDY_msg=1. On EN_msg:
  - capture id, clamped length L = min(msg_len, MAX_WORDS), and all payload words;
  - go to HDR;
  - if msg_len > MAX_WORDS, set err_len.
- HDR: RDY_beat=1, beat = {msg_id, (L+1) truncated to width/2}; the low half is the total beat count including the header. last=1 iff L=0.
  - On EN_beat: L=0 → IDLE; else → BODY with index 0.
- BODY: beat = payload word[index], last = (index == L-1).
  - On EN_beat: if last → IDLE; else index+1.
- Payload order: word 0 first. Words ≥ L are never emitted.
- EN_beat while RDY_beat=0 is ignored. EN_msg while RDY_msg=0 is ignored; the message is not captured.
- err_len clears only on reset.
- Reset, including mid-message: state→IDLE, partial message discarded. Outputs while nRST=1:
  - RDY_beat=0, beat=0, last=0, err_len=0;
  - RDY_msg=0.
- RDY_msg=1 from the first cycle after reset deasserts.

## Timing
- beat, last and RDY_beat are registered. RDY_msg is decoded from the state register and gated by !nRST.
- Accept at edge N → header valid in cycle N+1.
- With EN_beat held high, one beat per cycle. A message of L words occupies L+1 cycles on the beat port.
- Final beat consumed at edge M → RDY_msg=1 in cycle M+1. Next accept at earliest edge M+1, so the next header appears at M+2. There is a one-cycle bubble between messages.
- Backpressure: beat and last are held stable while RDY_beat=1 and EN_beat=0.

## Configuration
- VSIM_SER_STATS_EN defined: adds two outputs.
  - stat_msgs[31:0]: +1 per accepted message.
  - stat_beats[31:0]: +1 per consumed beat.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the stat ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package vsim_ser_pkg holds:
  - the state enum {IDLE, HDR, BODY};
  - function pack_header(id, count);
  - the LEN_W computation helper.
- One sub-module, vsim_ser_wordbuf: MAX_WORDS×width capture register with an index read port. The FSM owns the index and length.

## Test plan
- msg_id=16'h0005, msg_len=2, words 0xA1, 0xB2, EN_beat held 1 → beats 0x00050003, 0xA1, 0xB2 on consecutive cycles; last only on 0xB2; RDY_msg=1 the cycle after.
- msg_len=0, msg_id=16'h0007 → single beat 0x00070001 with last=1.
- Same 2-word message with EN_beat toggled 1,0,0,1,1 → beat/last stable during stalls; exactly 3 beats consumed, in order.
- msg_len=MAX_WORDS+3 → MAX_WORDS+1 beats emitted, header count = MAX_WORDS+1, err_len=1 and held across later good messages.
- nRST pulsed after the header of a 4-word message → RDY_beat=0 during reset; next message starts cleanly with its own header; err_len=0.
- Two back-to-back EN_msg pulses with VSIM_SER_STATS_EN defined → second message accepted only after the first's last beat; stat_msgs=2, stat_beats=total beats; EN_msg during busy is ignored.
